// File: rtl/ecg_beat_sequencer.sv
// Plays whole ECG heartbeats: BEAT_LEN SINE slots, then gap_len zero slots, repeated or counted.
// Latency: one register stage from sample_req_in to gen_sample_req/gen_control.
// No backpressure: every codec slot produces one request. Macro ECG_BEAT_SEQ_LOOPBACK_EN adds LOOP.
module ecg_beat_sequencer #(
    parameter int BEAT_LEN = 100,
    parameter int GAP_W    = 12,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_req_in,
    input  logic             start,
    input  logic             stop,
    input  logic             loopback_en,
    input  logic [GAP_W-1:0] gap_len,
    input  logic [CNT_W-1:0] beat_count,
    output logic             gen_sample_req,
    output logic [3:0]       gen_control,
    output logic             busy,
    output logic             beat_pulse,
    output logic             done,
    output logic [CNT_W-1:0] beat_idx
);

    localparam int PH_W = (BEAT_LEN > 1) ? $clog2(BEAT_LEN) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BEAT_LEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
`ifdef ECG_BEAT_SEQ_LOOPBACK_EN
    localparam logic [1:0] S_LOOP = 2'd3;
`endif

    logic [1:0]       state;
    logic [PH_W-1:0]  phase;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_lat;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_lat;
    logic [CNT_W-1:0] beat_inc;
    logic             stop_pend;
    logic [3:0]       ctrl_now;

    assign beat_inc = beat_cnt + 1'b1;
    assign busy     = (state != S_IDLE);
    assign beat_idx = beat_cnt;

    // Control word reflects the state the slot arrives in, before any transition it causes.
`ifdef ECG_BEAT_SEQ_LOOPBACK_EN
    assign ctrl_now = {2'b00, state == S_LOOP, state == S_BEAT};
`else
    assign ctrl_now = {3'b000, state == S_BEAT};
    logic unused_loopback;
    assign unused_loopback = loopback_en;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            phase          <= '0;
            gap_cnt        <= '0;
            gap_lat        <= '0;
            beat_cnt       <= '0;
            cnt_lat        <= '0;
            stop_pend      <= 1'b0;
            gen_sample_req <= 1'b0;
            gen_control    <= 4'b0000;
            beat_pulse     <= 1'b0;
            done           <= 1'b0;
        end else begin
            gen_sample_req <= sample_req_in;
            beat_pulse     <= 1'b0;
            done           <= 1'b0;
            if (sample_req_in) begin
                gen_control <= ctrl_now;
            end

            case (state)
                S_IDLE: begin
`ifdef ECG_BEAT_SEQ_LOOPBACK_EN
                    if (loopback_en) begin
                        state <= S_LOOP;
                    end else
`endif
                    if (start && !stop) begin
                        gap_lat   <= gap_len;
                        cnt_lat   <= beat_count;
                        phase     <= '0;
                        gap_cnt   <= '0;
                        beat_cnt  <= '0;
                        stop_pend <= 1'b0;
                        state     <= S_BEAT;
                    end
                end

                S_BEAT: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (sample_req_in) begin
                        if (phase == PH_LAST) begin
                            phase      <= '0;
                            beat_pulse <= 1'b1;
                            beat_cnt   <= beat_inc;
                            if (cnt_lat != '0 && beat_inc == cnt_lat) begin
                                done      <= 1'b1;
                                stop_pend <= 1'b0;
                                state     <= S_IDLE;
                            end else if (stop_pend) begin
                                stop_pend <= 1'b0;
                                state     <= S_IDLE;
                            end else if (gap_lat != '0) begin
                                state <= S_GAP;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (sample_req_in) begin
                        if (stop_pend) begin
                            gap_cnt   <= '0;
                            stop_pend <= 1'b0;
                            state     <= S_IDLE;
                        end else if (gap_cnt == gap_lat - 1'b1) begin
                            gap_cnt <= '0;
                            state   <= S_BEAT;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end

`ifdef ECG_BEAT_SEQ_LOOPBACK_EN
                S_LOOP: begin
                    if (!loopback_en) begin
                        state <= S_IDLE;
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecg_beat_sequencer.sv
// Scoreboard bench for ecg_beat_sequencer: slots push expected {control, beat_pulse, done},
// a negedge monitor pops and compares whenever gen_sample_req is high.
module tb_ecg_beat_sequencer;

    localparam int GAP_W = 12;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sample_req_in;
    logic             start;
    logic             stop;
    logic             loopback_en;
    logic [GAP_W-1:0] gap_len;
    logic [CNT_W-1:0] beat_count;
    logic             gen_sample_req;
    logic [3:0]       gen_control;
    logic             busy;
    logic             beat_pulse;
    logic             done;
    logic [CNT_W-1:0] beat_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int n_popped = 0;
    logic [5:0] exp_q[$];

    ecg_beat_sequencer #(.BEAT_LEN(100), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_req_in  (sample_req_in),
        .start          (start),
        .stop           (stop),
        .loopback_en    (loopback_en),
        .gap_len        (gap_len),
        .beat_count     (beat_count),
        .gen_sample_req (gen_sample_req),
        .gen_control    (gen_control),
        .busy           (busy),
        .beat_pulse     (beat_pulse),
        .done           (done),
        .beat_idx       (beat_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every output strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (gen_sample_req === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: got gen_sample_req=1, expected no strobe");
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    n_popped++;
                    chk($sformatf("strobe%0d gen_control", n_popped), 32'(gen_control), 32'(e[5:2]));
                    chk($sformatf("strobe%0d beat_pulse", n_popped), 32'(beat_pulse), 32'(e[1]));
                    chk($sformatf("strobe%0d done", n_popped), 32'(done), 32'(e[0]));
                end
            end else if (beat_pulse !== 1'b0 || done !== 1'b0) begin
                n_checks++;
                $display("FAIL stray_pulse: got beat_pulse=%b done=%b, expected 0 0", beat_pulse, done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_slot(input logic [3:0] c, input logic bp, input logic dn,
                           input logic with_stop = 1'b0, input logic with_start = 1'b0);
        exp_q.push_back({c, bp, dn});
        sample_req_in = 1'b1;
        stop          = with_stop;
        start         = with_start;
        tick();
        sample_req_in = 1'b0;
        stop          = 1'b0;
        start         = 1'b0;
        tick();
    endtask

    task automatic do_start(input int gap, input int cnt);
        gap_len    = GAP_W'(gap);
        beat_count = CNT_W'(cnt);
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sample_req_in = 1'b0; start = 1'b0; stop = 1'b0;
        loopback_en = 1'b0; gap_len = '0; beat_count = '0;
        repeat (3) tick();
        chk("reset gen_sample_req", 32'(gen_sample_req), 0);
        chk("reset gen_control", 32'(gen_control), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset beat_pulse", 32'(beat_pulse), 0);
        chk("reset done", 32'(done), 0);
        chk("reset beat_idx", 32'(beat_idx), 0);
        rst_n = 1'b1;
        tick();

        // Two beats with a 20-slot gap.
        do_start(20, 2);
        chk("t1 busy after start", 32'(busy), 1);
        for (int i = 1; i <= 300; i++)
            do_slot((i <= 100 || (i >= 121 && i <= 220)) ? 4'b0001 : 4'b0000,
                    (i == 100 || i == 220), (i == 220));
        chk("t1 beat_idx", 32'(beat_idx), 2);
        chk("t1 busy end", 32'(busy), 0);

        // Continuous, no gap; then a graceful stop.
        do_start(0, 0);
        for (int i = 1; i <= 300; i++)
            do_slot(4'b0001, (i % 100 == 0), 1'b0);
        chk("t2 busy continuous", 32'(busy), 1);
        chk("t2 beat_idx", 32'(beat_idx), 3);
        for (int i = 301; i <= 400; i++)
            do_slot(4'b0001, (i == 400), 1'b0, (i == 301));
        chk("t2 busy after stop", 32'(busy), 0);
        chk("t2 beat_idx final", 32'(beat_idx), 4);

        // Stop mid-beat.
        do_start(20, 0);
        for (int i = 1; i <= 105; i++)
            do_slot((i <= 100) ? 4'b0001 : 4'b0000, (i == 100), 1'b0, (i == 50));
        chk("t3 busy", 32'(busy), 0);

        // Stop inside the gap.
        do_start(30, 0);
        for (int i = 1; i <= 111; i++)
            do_slot((i <= 100) ? 4'b0001 : 4'b0000, (i == 100), 1'b0, (i == 110));
        chk("t4 busy after slot 111", 32'(busy), 0);
        for (int i = 112; i <= 140; i++)
            do_slot(4'b0000, 1'b0, 1'b0);

        // Start and stop together.
        gap_len = '0; beat_count = '0;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        chk("t5 start+stop busy", 32'(busy), 0);
        do_slot(4'b0000, 1'b0, 1'b0);

        // Slot coincident with start; single-beat run.
        gap_len = '0; beat_count = CNT_W'(1);
        do_slot(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 100; i++)
            do_slot(4'b0001, (i == 100), (i == 100));
        chk("t6 busy", 32'(busy), 0);
        chk("t6 beat_idx", 32'(beat_idx), 1);

        // Reset in the middle of a beat.
        do_start(0, 0);
        for (int i = 1; i <= 36; i++)
            do_slot(4'b0001, 1'b0, 1'b0);
        sample_req_in = 1'b1; rst_n = 1'b0;
        tick();
        sample_req_in = 1'b0;
        chk("t7 rst gen_sample_req", 32'(gen_sample_req), 0);
        chk("t7 rst gen_control", 32'(gen_control), 0);
        chk("t7 rst busy", 32'(busy), 0);
        chk("t7 rst beat_idx", 32'(beat_idx), 0);
        rst_n = 1'b1;
        tick();
        do_slot(4'b0000, 1'b0, 1'b0);

        // Loopback request.
        loopback_en = 1'b1;
        tick(); tick();
`ifdef ECG_BEAT_SEQ_LOOPBACK_EN
        chk("t8 loop busy", 32'(busy), 1);
        for (int i = 1; i <= 5; i++) do_slot(4'b0010, 1'b0, 1'b0);
`else
        chk("t8 loop busy", 32'(busy), 0);
        for (int i = 1; i <= 5; i++) do_slot(4'b0000, 1'b0, 1'b0);
`endif
        loopback_en = 1'b0;
        tick();
        do_slot(4'b0000, 1'b0, 1'b0);
        chk("t8 busy after drop", 32'(busy), 0);

        repeat (4) tick();
        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
